// File: rtl/seq_detect_param_if.sv
// Bus bundle for seq_detect_param: sample strobe and raw buttons in,
// bit/detect/error indications out.
interface seq_detect_param_if #(
   parameter int unsigned SEQ_LEN = 4,
   parameter int unsigned CNT_W   = 8
);
   localparam int unsigned SW = $clog2(SEQ_LEN + 1);

   logic             tick;
   logic             btn_0;
   logic             btn_1;
   logic             bit_valid;
   logic             bit_val;
   logic             out;
   logic             match_pulse;
   logic [CNT_W-1:0] match_count;
   logic [SW-1:0]    present_state;
   logic             err_pulse;

   modport master (
      output tick, btn_0, btn_1,
      input  bit_valid, bit_val, out, match_pulse, match_count, present_state, err_pulse
   );

   modport slave (
      input  tick, btn_0, btn_1,
      output bit_valid, bit_val, out, match_pulse, match_count, present_state, err_pulse
   );
endinterface

// File: rtl/seq_detect_param.sv
// Pushbutton serial pattern detector: 2-FF sync + tick-based debounce per button,
// shift history with fill count, Moore detect level and saturating match counter.
module seq_detect_param #(
   parameter int unsigned          SEQ_LEN        = 4,
   parameter logic [SEQ_LEN-1:0]   PATTERN        = 4'b1011,
   parameter bit                   OVERLAP        = 1'b1,
   parameter int unsigned          DEBOUNCE_TICKS = 4,
   parameter int unsigned          CNT_W          = 8
) (
   input  logic              clk_in,
   input  logic              clear,
   seq_detect_param_if.slave bus
);
   localparam int unsigned SW = $clog2(SEQ_LEN + 1);
   localparam int unsigned CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_TICKS - 1);

   logic [1:0]         w_btn;
   logic [1:0]         r_meta;
   logic [1:0]         r_sync;
   logic [1:0]         r_stable;
   logic [1:0]         r_press;
   logic [CW-1:0]      r_cnt [2];

   logic [SEQ_LEN-1:0] r_hist;
   logic [SW-1:0]      r_fill;
   logic               r_out;
   logic               r_match;
   logic               r_last_bit;
   logic [CNT_W-1:0]   r_count;

   logic               w_accept;
   logic               w_err;
   logic               w_bit;
   logic [SEQ_LEN-1:0] w_new_hist;
   logic [SW-1:0]      w_new_fill;
   logic               w_match;
   logic [SW-1:0]      w_state;
   logic               w_ok;

   assign w_btn = {bus.btn_1, bus.btn_0};

   // r_press marks the cycle right after a stable 0->1 flip; releases never set it.
   always_ff @(posedge clk_in or posedge clear) begin
      if (clear) begin
         r_meta   <= '0;
         r_sync   <= '0;
         r_stable <= '0;
         r_press  <= '0;
         for (int unsigned b = 0; b < 2; b++) r_cnt[b] <= '0;
      end else begin
         r_meta  <= w_btn;
         r_sync  <= r_meta;
         r_press <= '0;
         if (bus.tick) begin
            for (int unsigned b = 0; b < 2; b++) begin
               if (r_sync[b] == r_stable[b]) begin
                  r_cnt[b] <= '0;
               end else if (r_cnt[b] == CNT_MAX) begin
                  r_stable[b] <= r_sync[b];
                  r_press[b]  <= r_sync[b];
                  r_cnt[b]    <= '0;
               end else begin
                  r_cnt[b] <= r_cnt[b] + 1'b1;
               end
            end
         end
      end
   end

   assign w_accept   = r_press[0] ^ r_press[1];
   assign w_err      = r_press[0] & r_press[1];
   assign w_bit      = r_press[1];
   assign w_new_hist = {r_hist[SEQ_LEN-2:0], w_bit};
   assign w_new_fill = (r_fill == SW'(SEQ_LEN)) ? r_fill : r_fill + 1'b1;
   assign w_match    = w_accept && (w_new_fill == SW'(SEQ_LEN)) && (w_new_hist == PATTERN);

   always_ff @(posedge clk_in or posedge clear) begin
      if (clear) begin
         r_hist     <= '0;
         r_fill     <= '0;
         r_out      <= 1'b0;
         r_match    <= 1'b0;
         r_last_bit <= 1'b0;
         r_count    <= '0;
      end else begin
         r_match <= w_match;
         if (w_accept) begin
            r_last_bit <= w_bit;
            r_hist     <= w_new_hist;
            r_out      <= w_match;
            r_fill     <= (w_match && !OVERLAP) ? '0 : w_new_fill;
            if (w_match && (r_count != '1)) r_count <= r_count + 1'b1;
         end
      end
   end

   // Longest suffix of the received bits (bounded by fill) that is a pattern prefix.
   always_comb begin
      w_state = '0;
      w_ok    = 1'b0;
      for (int unsigned k = 1; k <= SEQ_LEN; k++) begin
         w_ok = (SW'(k) <= r_fill);
         for (int unsigned j = 0; j < k; j++) begin
            if (r_hist[j] != PATTERN[SEQ_LEN-k+j]) w_ok = 1'b0;
         end
         if (w_ok) w_state = SW'(k);
      end
   end

   assign bus.bit_valid     = w_accept;
   assign bus.bit_val       = w_accept ? w_bit : r_last_bit;
   assign bus.out           = r_out;
   assign bus.match_pulse   = r_match;
   assign bus.match_count   = r_count;
   assign bus.present_state = w_state;
   assign bus.err_pulse     = w_err;
endmodule

// File: tb/tb_seq_detect_param.sv
// Three detector variants (default, OVERLAP=0, CNT_W=2) driven by the same button
// stimulus; a scoreboard queue holds hand-computed responses popped by a monitor.
module tb_seq_detect_param;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic clear, tick, b0, b1;
   int   checks = 0;
   int   errors = 0;
   int   phase  = 0;

   seq_detect_param_if #(.SEQ_LEN(4), .CNT_W(8)) ifa ();
   seq_detect_param_if #(.SEQ_LEN(4), .CNT_W(8)) ifb ();
   seq_detect_param_if #(.SEQ_LEN(4), .CNT_W(2)) ifc ();

   assign ifa.tick = tick;  assign ifa.btn_0 = b0;  assign ifa.btn_1 = b1;
   assign ifb.tick = tick;  assign ifb.btn_0 = b0;  assign ifb.btn_1 = b1;
   assign ifc.tick = tick;  assign ifc.btn_0 = b0;  assign ifc.btn_1 = b1;

   seq_detect_param u_ov (.clk_in(clk), .clear(clear), .bus(ifa));
   seq_detect_param #(.OVERLAP(1'b0)) u_no (.clk_in(clk), .clear(clear), .bus(ifb));
   seq_detect_param #(.CNT_W(2)) u_c2 (.clk_in(clk), .clear(clear), .bus(ifc));

   logic [2:0] bv, bval, mp, outv, errp;
   logic [7:0] cnt [3];
   logic [2:0] ps  [3];
   assign bv   = {ifc.bit_valid,   ifb.bit_valid,   ifa.bit_valid};
   assign bval = {ifc.bit_val,     ifb.bit_val,     ifa.bit_val};
   assign mp   = {ifc.match_pulse, ifb.match_pulse, ifa.match_pulse};
   assign outv = {ifc.out,         ifb.out,         ifa.out};
   assign errp = {ifc.err_pulse,   ifb.err_pulse,   ifa.err_pulse};
   assign cnt[0] = ifa.match_count;
   assign cnt[1] = ifb.match_count;
   assign cnt[2] = {6'b0, ifc.match_count};
   assign ps[0]  = ifa.present_state;
   assign ps[1]  = ifb.present_state;
   assign ps[2]  = ifc.present_state;

   // Expected state after each accepted bit, nibbles {present_state, match_pulse, match_count, out}.
   logic       BITS [28] = '{1,1, 1,0,1,1,0,1,1, 1,0,1, 1,0,1,1,0,1,1,0,1,1,0,1,1,0,1,1};
   logic [15:0] EOV [28] = '{16'h1000,16'h1000,
      16'h1000,16'h2000,16'h3000,16'h4111,16'h2010,16'h3010,16'h4121,
      16'h1020,16'h2020,16'h3020,
      16'h1000,16'h2000,16'h3000,16'h4111,16'h2010,16'h3010,16'h4121,16'h2020,
      16'h3020,16'h4131,16'h2030,16'h3030,16'h4141,16'h2040,16'h3040,16'h4151};
   logic [15:0] ENO [28] = '{16'h1000,16'h1000,
      16'h1000,16'h2000,16'h3000,16'h0111,16'h0010,16'h1010,16'h1010,
      16'h1010,16'h2010,16'h3010,
      16'h1000,16'h2000,16'h3000,16'h0111,16'h0010,16'h1010,16'h1010,16'h2010,
      16'h3010,16'h0121,16'h0020,16'h1020,16'h1020,16'h2020,16'h3020,16'h0131};
   logic [15:0] EC2 [28] = '{16'h1000,16'h1000,
      16'h1000,16'h2000,16'h3000,16'h4111,16'h2010,16'h3010,16'h4121,
      16'h1020,16'h2020,16'h3020,
      16'h1000,16'h2000,16'h3000,16'h4111,16'h2010,16'h3010,16'h4121,16'h2020,
      16'h3020,16'h4131,16'h2030,16'h3030,16'h4131,16'h2030,16'h3030,16'h4131};

   typedef struct packed {
      logic        b;
      logic [15:0] e0, e1, e2;
   } exp_t;
   typedef struct packed {
      logic [2:0] p0; logic o0;
      logic [2:0] p1; logic o1;
      logic [2:0] p2; logic o2;
   } err_t;

   exp_t bq [$];
   err_t eq [$];

   // Monitor: checks bit_val on bit_valid, then the next cycle's detect outputs.
   initial begin
      logic        pend [3];
      logic [15:0] pexp [3];
      logic [15:0] got;
      exp_t        e;
      err_t        r;
      logic [3:0]  er [3];
      for (int d = 0; d < 3; d++) pend[d] = 1'b0;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            if (pend[d]) begin
               checks++;
               got = {1'b0, ps[d], 3'b0, mp[d], cnt[d][3:0], 3'b0, outv[d]};
               if (got !== pexp[d] || cnt[d][7:4] != 4'h0) begin
                  errors++;
                  $display("FAIL detect dut%0d: got ps/mp/cnt/out=%h (cnt=%0d) required %h", d, got, cnt[d], pexp[d]);
               end
               pend[d] = 1'b0;
            end else if (mp[d]) begin
               checks++; errors++;
               $display("FAIL spurious_match dut%0d: match_pulse=1 required 0", d);
            end
         end
         if (bv != 3'b000) begin
            if (bq.size() == 0) begin
               checks++; errors++;
               $display("FAIL spurious_bit: bit_valid=%b required 000", bv);
            end else begin
               e = bq.pop_front();
               pexp[0] = e.e0; pexp[1] = e.e1; pexp[2] = e.e2;
               for (int d = 0; d < 3; d++) begin
                  checks++;
                  if (bv[d] !== 1'b1 || bval[d] !== e.b) begin
                     errors++;
                     $display("FAIL bit dut%0d: valid=%b val=%b required valid=1 val=%b", d, bv[d], bval[d], e.b);
                  end
                  pend[d] = 1'b1;
               end
            end
         end
         if (errp != 3'b000) begin
            if (eq.size() == 0) begin
               checks++; errors++;
               $display("FAIL spurious_err: err_pulse=%b required 000", errp);
            end else begin
               r = eq.pop_front();
               er[0] = {r.p0, r.o0}; er[1] = {r.p1, r.o1}; er[2] = {r.p2, r.o2};
               for (int d = 0; d < 3; d++) begin
                  checks++;
                  if (errp[d] !== 1'b1 || bv[d] !== 1'b0 || {ps[d], outv[d]} !== er[d]) begin
                     errors++;
                     $display("FAIL collision dut%0d: err=%b valid=%b ps=%0d out=%b required err=1 valid=0 ps=%0d out=%b",
                              d, errp[d], bv[d], ps[d], outv[d], er[d][3:1], er[d][0]);
                  end
               end
            end
         end
      end
   end

   task automatic clk1();
      @(negedge clk);
      phase = (phase + 1) % 4;
      tick  = (phase == 0);
   endtask

   // Returns at the negedge just after the n-th tick has been sampled.
   task automatic run_ticks(input int n);
      int k;
      k = 0;
      while (k < n) begin
         clk1();
         if (tick) k++;
      end
      clk1();
   endtask

   task automatic check_zero(input string name);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({bv[d], bval[d], mp[d], outv[d], errp[d], cnt[d], ps[d]} !== 16'h0) begin
            errors++;
            $display("FAIL %s dut%0d: valid=%b val=%b mp=%b out=%b err=%b cnt=%0d ps=%0d required all 0",
                     name, d, bv[d], bval[d], mp[d], outv[d], errp[d], cnt[d], ps[d]);
         end
      end
   endtask

   task automatic do_clear(input string name);
      #2 clear = 1'b1;
      #1 check_zero(name);
      clk1();
      clk1();
      clear = 1'b0;
      while (phase != 1) clk1();
   endtask

   task automatic check_lat();
      checks++;
      if (bv !== 3'b111) begin
         errors++;
         $display("FAIL press_latency: bit_valid=%b required 111", bv);
      end
   endtask

   task automatic push_bit(input int i);
      bq.push_back('{BITS[i], EOV[i], ENO[i], EC2[i]});
   endtask

   task automatic press(input int i);
      push_bit(i);
      if (BITS[i]) b1 = 1'b1; else b0 = 1'b1;
      run_ticks(4);
      check_lat();
      b0 = 1'b0; b1 = 1'b0;
      run_ticks(4);
   endtask

   initial begin
      clear = 1'b1; tick = 1'b0; b0 = 1'b0; b1 = 1'b0;
      repeat (2) @(negedge clk);
      do_clear("reset");

      // Debounce: 3-tick glitch, exact 4-tick hold, 20-tick hold.
      b1 = 1'b1; run_ticks(3); b1 = 1'b0; run_ticks(4);
      push_bit(0);
      b1 = 1'b1; run_ticks(4); check_lat(); b1 = 1'b0; run_ticks(4);
      push_bit(1);
      b1 = 1'b1; run_ticks(4); check_lat(); run_ticks(16); b1 = 1'b0; run_ticks(4);
      do_clear("clear_after_debounce");

      for (int i = 2; i < 9; i++) press(i);

      eq.push_back('{3'd4, 1'b1, 3'd1, 1'b0, 3'd4, 1'b1});
      b0 = 1'b1; b1 = 1'b1; run_ticks(4);
      checks++;
      if (errp !== 3'b111) begin
         errors++;
         $display("FAIL err_latency: err_pulse=%b required 111", errp);
      end
      b0 = 1'b0; b1 = 1'b0; run_ticks(4);

      for (int i = 9; i < 12; i++) press(i);
      do_clear("clear_mid");
      for (int i = 12; i < 28; i++) press(i);

      run_ticks(2);
      checks++;
      if (bq.size() != 0 || eq.size() != 0) begin
         errors++;
         $display("FAIL pending: bits=%0d errs=%0d left required 0", bq.size(), eq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
